// File: rtl/benes_pkg.sv
// Shared sizing, types and state encoding for the 8x8 Benes fabric configuration path.
// Stage s of a fabric configuration lives at bits [s*SPS +: SPS].
package benes_pkg;
  localparam int N      = 8;
  localparam int STAGES = 2 * $clog2(N) - 1;
  localparam int SPS    = N / 2;
  localparam int CFG_W  = STAGES * SPS;
  localparam int CNT_W  = $clog2(STAGES);

  typedef logic [SPS-1:0]   stage_cfg_t;
  typedef logic [CFG_W-1:0] fabric_cfg_t;
  typedef logic [CNT_W-1:0] beat_cnt_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } cfg_state_e;

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(STAGES - 1);
endpackage

// File: rtl/benes_cfg_loader_if.sv
// Host-to-loader beat channel: one stage of switch settings per valid/ready transfer.
interface benes_cfg_loader_if;
  import benes_pkg::*;

  stage_cfg_t cfg_data;
  logic       cfg_valid;
  logic       cfg_last;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, output cfg_last, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_last, output cfg_ready);
endinterface

// File: rtl/benes_cfg_loader.sv
// Assembles per-stage beats into a shadow configuration and commits it atomically
// to the Benes switch array; switch (s,k) is driven by switch_set[s*SPS+k].
module benes_cfg_loader
  import benes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  benes_cfg_loader_if.slave   cfg,
  input  logic                apply_req,
  output fabric_cfg_t         switch_set,
  output logic                cfg_full,
  output logic                cfg_applied,
  output logic                cfg_err
);

  cfg_state_e  state_r;
  cfg_state_e  state_nxt_s;
  beat_cnt_t   beat_cnt_r;
  beat_cnt_t   beat_cnt_nxt_s;
  fabric_cfg_t shadow_r;
  fabric_cfg_t active_r;
  logic        cfg_ready_r;
  logic        cfg_full_r;
  logic        cfg_applied_r;
  logic        cfg_err_r;
  logic        xfer_s;
  logic        shadow_we_s;
  logic        apply_s;
  logic        err_s;

  assign xfer_s        = cfg.cfg_valid & cfg_ready_r;
  assign cfg.cfg_ready = cfg_ready_r;
  assign switch_set    = active_r;
  assign cfg_full      = cfg_full_r;
  assign cfg_applied   = cfg_applied_r;
  assign cfg_err       = cfg_err_r;

  // Next-state, beat counter and frame-framing checks.
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    shadow_we_s    = 1'b0;
    apply_s        = 1'b0;
    err_s          = 1'b0;
    case (state_r)
      FILL: begin
        if (xfer_s) begin
          shadow_we_s = 1'b1;
          if (beat_cnt_r == LAST_BEAT) begin
            beat_cnt_nxt_s = '0;
            if (cfg.cfg_last) begin
              state_nxt_s = FULL;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            if (cfg.cfg_last) begin
              beat_cnt_nxt_s = '0;
              err_s          = 1'b1;
            end else begin
              beat_cnt_nxt_s = beat_cnt_r + beat_cnt_t'(1);
            end
          end
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      FULL: begin
        if (apply_req) begin
          apply_s     = 1'b1;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s    = FILL;
        beat_cnt_nxt_s = '0;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FILL;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

  // Shadow capture and atomic commit to the active switch settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
      active_r <= '0;
    end else begin
      if (shadow_we_s) begin
        shadow_r[beat_cnt_r*SPS +: SPS] <= cfg.cfg_data;
      end
      if (apply_s) begin
        active_r <= shadow_r;
      end
    end
  end

  // Registered status; ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_r   <= 1'b0;
      cfg_full_r    <= 1'b0;
      cfg_applied_r <= 1'b0;
      cfg_err_r     <= 1'b0;
    end else begin
      cfg_ready_r   <= (state_nxt_s == FILL);
      cfg_full_r    <= (state_nxt_s == FULL);
      cfg_applied_r <= apply_s;
      cfg_err_r     <= err_s;
    end
  end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Directed bench for benes_cfg_loader: framing, commit latency, handshake gaps and reset.
module tb_benes_cfg_loader;
  import benes_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        apply_req;
  fabric_cfg_t switch_set;
  logic        cfg_full;
  logic        cfg_applied;
  logic        cfg_err;
  int          total;
  int          bad;

  benes_cfg_loader_if cfg_if ();

  benes_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg_if),
    .apply_req  (apply_req),
    .switch_set (switch_set),
    .cfg_full   (cfg_full),
    .cfg_applied(cfg_applied),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one beat from the falling edge, let the next rising edge take it.
  task automatic beat(input logic [3:0] d, input logic l);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    cfg_if.cfg_last  = l;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic commit();
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    apply_req        = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic drop_apply();
    @(negedge clk);
    apply_req        = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] d5 [5];
    int         g5 [5];
    total            = 0;
    bad              = 0;
    rst_n            = 1'b0;
    apply_req        = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 4'h0;
    cfg_if.cfg_last  = 1'b0;

    // 1 reset
    #3;
    chk("rst_sw", 32'(switch_set), 32'h0);
    chk("rst_rdy", 32'(cfg_if.cfg_ready), 32'h0);
    chk("rst_full", 32'(cfg_full), 32'h0);
    chk("rst_pulses", 32'({cfg_applied, cfg_err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("rdy_after_rel", 32'(cfg_if.cfg_ready), 32'h1);

    // 2 good frame
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    beat(4'h4, 1'b0);
    beat(4'h8, 1'b0);
    chk("mid_frame_full", 32'(cfg_full), 32'h0);
    beat(4'hF, 1'b1);
    chk("good_full", 32'(cfg_full), 32'h1);
    chk("good_rdy", 32'(cfg_if.cfg_ready), 32'h0);
    chk("good_sw_pre", 32'(switch_set), 32'h0);
    commit();
    chk("good_sw", 32'(switch_set), 32'hF8421);
    chk("good_applied", 32'(cfg_applied), 32'h1);
    chk("good_full_clr", 32'(cfg_full), 32'h0);
    chk("good_rdy_back", 32'(cfg_if.cfg_ready), 32'h1);
    drop_apply();
    chk("applied_pulse_end", 32'(cfg_applied), 32'h0);

    // 3 short frame then good frame
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b1);
    chk("short_err", 32'(cfg_err), 32'h1);
    chk("short_full", 32'(cfg_full), 32'h0);
    chk("short_sw", 32'(switch_set), 32'hF8421);
    idle(1);
    chk("short_err_end", 32'(cfg_err), 32'h0);
    beat(4'h3, 1'b0);
    beat(4'h5, 1'b0);
    beat(4'h7, 1'b0);
    beat(4'h9, 1'b0);
    beat(4'h6, 1'b1);
    chk("after_short_full", 32'(cfg_full), 32'h1);
    commit();
    chk("after_short_sw", 32'(switch_set), 32'h69753);
    drop_apply();

    // 4 long frame; sixth beat restarts at stage 0
    for (int i = 0; i < 4; i++) beat(4'h4, 1'b0);
    chk("long_no_err_yet", 32'(cfg_err), 32'h0);
    beat(4'h4, 1'b0);
    chk("long_err", 32'(cfg_err), 32'h1);
    chk("long_full", 32'(cfg_full), 32'h0);
    beat(4'hC, 1'b0);
    chk("long_err_end", 32'(cfg_err), 32'h0);
    beat(4'hD, 1'b0);
    beat(4'hE, 1'b0);
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b1);
    chk("restart_full", 32'(cfg_full), 32'h1);
    commit();
    chk("restart_sw", 32'(switch_set), 32'h21EDC);
    drop_apply();

    // 5 valid gaps with apply_req held high through FILL
    d5 = '{4'h7, 4'h0, 4'hB, 4'h3, 4'h5};
    g5 = '{0, 2, 1, 3, 0};
    @(negedge clk);
    apply_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(g5[i]);
      beat(d5[i], (i == 4) ? 1'b1 : 1'b0);
      if (i == 2) begin
        chk("gap_no_early_sw", 32'(switch_set), 32'h21EDC);
        chk("gap_no_applied", 32'(cfg_applied), 32'h0);
      end
    end
    chk("gap_full", 32'(cfg_full), 32'h1);
    chk("gap_sw_hold", 32'(switch_set), 32'h21EDC);
    chk("gap_applied_hold", 32'(cfg_applied), 32'h0);
    commit();
    chk("gap_sw", 32'(switch_set), 32'h53B07);
    chk("gap_applied", 32'(cfg_applied), 32'h1);
    drop_apply();

    // 6 reset while FULL after committing all-A
    for (int i = 0; i < 4; i++) beat(4'hA, 1'b0);
    beat(4'hA, 1'b1);
    commit();
    chk("aa_sw", 32'(switch_set), 32'hAAAAA);
    drop_apply();
    for (int i = 0; i < 4; i++) beat(4'h5, 1'b0);
    beat(4'h5, 1'b1);
    chk("pre_rst_full", 32'(cfg_full), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_full_sw", 32'(switch_set), 32'h0);
    chk("rst_full_full", 32'(cfg_full), 32'h0);
    chk("rst_full_rdy", 32'(cfg_if.cfg_ready), 32'h0);
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_full_rdy_rel", 32'(cfg_if.cfg_ready), 32'h1);
    commit();
    chk("discard_no_commit", 32'(switch_set), 32'h0);
    chk("discard_no_applied", 32'(cfg_applied), 32'h0);
    drop_apply();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
